// File: rtl/seg7_time_scan.sv
// rtl/seg7_time_scan.sv - six-digit multiplexed 7-seg driver with per-frame coherent time snapshot
// Optional LEAD_ZERO_BLANK_EN: blank the hour-tens digit when it is zero.
module seg7_time_scan #(
  parameter int SCAN_DIV = 200_000,
  parameter int GUARD    = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0][3:0] hour,
  input  logic [1:0][3:0] minute,
  input  logic [1:0][3:0] second,
  output logic [5:0]      an,
  output logic [6:0]      seg,
  output logic            dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [23:0]   snap;
  logic [3:0]    digit;
  logic          in_guard;
  logic          blank;
  logic          slot_end;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    digit = snap[3:0];
    case (idx)
      3'd1:    digit = snap[7:4];
      3'd2:    digit = snap[11:8];
      3'd3:    digit = snap[15:12];
      3'd4:    digit = snap[19:16];
      3'd5:    digit = snap[23:20];
      default: digit = snap[3:0];
    endcase
  end

  assign in_guard = (cnt < GUARD_C);
  assign slot_end = (cnt == CNT_LAST);

`ifdef LEAD_ZERO_BLANK_EN
  assign blank = (idx == 3'd5) && (snap[23:20] == 4'd0);
`else
  assign blank = 1'b0;
`endif

  // Snapshot is taken only at the very last cycle of the frame so every frame shows one time.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
      an   <= '0;
      seg  <= '0;
      dp   <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        if (idx == 3'd5)
          snap <= {hour, minute, second};
      end
      an  <= in_guard ? 6'd0 : (6'd1 << idx);
      seg <= blank ? 7'd0 : decode(digit);
      dp  <= !in_guard && ((idx == 3'd4) || (idx == 3'd2)) && !snap[0];
    end
  end

endmodule

// File: tb/tb_seg7_time_scan.sv
// tb/tb_seg7_time_scan.sv - randomized scoreboard bench for seg7_time_scan
module tb_seg7_time_scan;

  localparam int SD = 4;
  localparam int G  = 1;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  logic            clk;
  logic            resetn;
  logic [1:0][3:0] hour;
  logic [1:0][3:0] minute;
  logic [1:0][3:0] second;
  logic [5:0]      an;
  logic [6:0]      seg;
  logic            dp;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [6:0] lut [16];

  seg7_time_scan #(.SCAN_DIV(SD), .GUARD(G)) dut (
    .clk(clk), .resetn(resetn), .hour(hour), .minute(minute), .second(second),
    .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F;
    lut[4] = 7'h66; lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07;
    lut[8] = 7'h7F; lut[9] = 7'h6F;
    for (int i = 10; i < 16; i++) lut[i] = 7'h40;
  end

  // Reference: time since reset release decides slot/phase; the frame shows the inputs
  // present on the last edge of the previous frame (zeros for the first frame).
  initial begin
    int k;
    int t;
    int slot;
    int ph;
    logic [23:0] shown;
    logic [3:0]  d;
    obs_t e;
    k = 0;
    shown = '0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        k = 0;
        shown = '0;
        exp_q.push_back('0);
      end else begin
        t = k;
        k++;
        slot = (t / SD) % 6;
        ph   = t % SD;
        d    = shown[slot*4 +: 4];
        e.an  = (ph < G) ? 6'd0 : 6'(1 << slot);
        e.seg = lut[d];
`ifdef LEAD_ZERO_BLANK_EN
        if (slot == 5 && d == 4'd0) e.seg = 7'd0;
`endif
        e.dp  = (ph >= G) && (slot == 4 || slot == 2) && (shown[0] == 1'b0);
        exp_q.push_back(e);
        if (t % (6 * SD) == 6 * SD - 1)
          shown = {hour, minute, second};
      end
    end
  end

  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          errors++;
          $display("FAIL outputs @%0t: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                   $time, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour   = {4'(h / 10), 4'(h % 10)};
    minute = {4'(m / 10), 4'(m % 10)};
    second = {4'(s / 10), 4'(s % 10)};
  endtask

  function automatic logic [3:0] rnd_digit();
    return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
  endfunction

  initial begin
    resetn = 1'b0;
    set_time(23, 59, 59);
    tick(3);
    resetn = 1'b1;
    tick(6 * SD);
    set_time(12, 34, 56);
    tick(6 * SD + 5);
    set_time(12, 35, 0);
    tick(3 * 6 * SD);
    set_time(12, 34, 56);
    tick(2 * 6 * SD);
    set_time(12, 34, 57);
    tick(2 * 6 * SD);
    second[0] = 4'hB;
    tick(2 * 6 * SD);
    set_time(9, 0, 0);
    tick(2 * 6 * SD);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(3 * SD + 2);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(2 * 6 * SD);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        hour   = {rnd_digit(), rnd_digit()};
        minute = {rnd_digit(), rnd_digit()};
        second = {rnd_digit(), rnd_digit()};
      end
      resetn = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    resetn = 1'b1;
    tick(4);
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL drain: got %0d pending, want at most 1", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_time_scan.md
# seg7_time_scan

Multiplexed six-digit seven-segment driver for the BCD time-of-day counter. It consumes the packed hour/minute/second BCD digits and scans one digit at a time onto a shared segment bus with one-hot digit enables. All six digits are captured as one coherent snapshot at each frame boundary, so a carry in the counter never shows a torn time. It sits between the time-counter outputs and the board display pins.

## Interface
- SCAN_DIV, 200_000: clk cycles per digit slot; ≥ 2 (100 in simulation builds).
- GUARD, 2: leading cycles of each slot with all digit enables off (anti-ghosting); 0 ≤ GUARD < SCAN_DIV.
- clk  input  1  system clock.
- resetn  input  1  reset, synchronous, active-low.
- hour  input  [1:0][3:0]  BCD hour; [1] tens, [0] ones.
- minute  input  [1:0][3:0]  BCD minute; [1] tens, [0] ones.
- second  input  [1:0][3:0]  BCD second; [1] tens, [0] ones.
- an  output  6  one-hot digit enable, active-high; bit 5 = hour tens … bit 0 = second ones.
- seg  output  7  segments gfedcba, active-high; seg[0] = a.
- dp  output  1  decimal point / separator, active-high.

## Operation
- Internal state: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..5), 24-bit snapshot snap.
- Digit mapping: idx 5 = snap hour[1], 4 = hour[0], 3 = minute[1], 2 = minute[0], 1 = second[1], 0 = second[0].
- cnt increments every cycle; at cnt == SCAN_DIV-1 it wraps to 0 and idx advances 0→1→…→5→0.
- Snapshot: on the cycle with idx == 5 and cnt == SCAN_DIV-1, snap loads all six input digits; the frame that starts next shows exactly those values. Inputs are not sampled at any other time.
- Decode: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; any value 10–15 shows dash 0x40.
- an = 0 while cnt < GUARD, else 1 << idx. seg is driven with the current digit pattern for the whole slot, including guard cycles.
- dp = 1 only for idx 4 and idx 2, outside guard cycles, when snap second[0] bit 0 == 0 (separator blinks with even/odd seconds); otherwise 0.

## Timing
- an, seg, dp are registered: value at edge t+1 is the function of cnt/idx/snap at edge t (one-cycle latency).
- Reset (resetn low at a clk edge): cnt = 0, idx = 0, snap = 0, an = 0, seg = 0, dp = 0. Reset overrides any in-progress slot or snapshot load.
- First cycle after reset release: cnt = 0; the next edge outputs an = 0 if GUARD > 0, seg = 0x3F. The first frame displays all zeros (snap cleared); first real snapshot loads at the end of slot 5.
- Frame period = 6·SCAN_DIV cycles; slot period = SCAN_DIV cycles.
- GUARD = 0: an is never blanked; no dead cycles between slots.
- Input changes on the snapshot-load cycle itself are captured; changes one cycle later wait a full frame.

## Configuration
- LEAD_ZERO_BLANK_EN defined: when snap hour[1] == 0, slot idx 5 drives seg = 0 (an still asserts normally), suppressing the leading hour zero.
- Not defined: hour tens 0 displays 0x3F like any other digit.

## Test plan
- Reset: hold resetn low 3 cycles with nonzero inputs -> an = 0, seg = 0, dp = 0; after release first frame shows 0x3F on all six slots.
- Scan order, SCAN_DIV = 4, GUARD = 1: -> an sequence per slot 0,1,1,1 (value 000001), then 0,2,2,2, … through 100000, wrapping every 24 cycles.
- Coherence: inputs 12:34:56 loaded; change to 12:35:00 mid-frame -> remaining slots still show 3,4,5,6 patterns; next frame shows 0x4F,0x6D,0x3F,0x3F for minute/second digits.
- Invalid BCD: second[0] = 4'hB -> slot 0 seg = 0x40; other slots unaffected.
- Separator: second[0] = 6 then 7 across frames -> dp = 1 in slots 4 and 2 (non-guard cycles) for 6, dp = 0 everywhere for 7.
- Macro: hour = 09 -> slot 5 seg = 0 with LEAD_ZERO_BLANK_EN, 0x3F without; reset asserted mid-slot 3 -> all outputs 0 next edge, scan restarts at idx 0.
